// File: rtl/dec_onehot_seq.sv
// ---------------------------------------------------------------------------
// dec_onehot_seq
//
// One-hot decoder with two active behaviours:
//   DIRECT : a load strobe captures sel into idx and drives d = 1 << sel.
//            An out-of-range sel clears d and pulses err for one cycle.
//   SCAN   : d walks 1 << 0 .. 1 << (N_OUT-1). Each position is held for
//            DWELL cycles. wrap pulses on the cycle d returns to bit 0.
// en = 0 parks the block in IDLE with every output cleared. Every output
// comes straight from a flop, so no input reaches an output within a cycle.
// ---------------------------------------------------------------------------
module dec_onehot_seq #(
  parameter int N_OUT = 6,      // number of one-hot outputs, 2..16
  parameter int SEL_W = 3,      // select width, 2**SEL_W >= N_OUT
  parameter int DWELL = 4       // cycles per scan step, 1..65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             ld,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] d,
  output logic [SEL_W-1:0] idx,
  output logic             wrap,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // The dwell counter needs at least one bit, even when DWELL is 1.
  localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  IDX_LAST = SEL_W'(N_OUT - 1);
  localparam logic [N_OUT-1:0]  OH_FIRST = N_OUT'(1);

  state_e           state_q;
  logic [N_OUT-1:0] d_q;
  logic [SEL_W-1:0] idx_q;
  logic             wrap_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  // Decode the direct-mode select. The shift alone would already give zero
  // for a large sel. The explicit range test also drives err.
  logic             sel_in_range;
  logic [N_OUT-1:0] sel_onehot;
  logic             scan_at_last;
  logic             dwell_done;

  assign sel_in_range = (sel <= IDX_LAST);
  assign sel_onehot   = sel_in_range ? (OH_FIRST << sel) : '0;
  assign scan_at_last = (idx_q == IDX_LAST);
  assign dwell_done   = (cnt_q == CNT_LAST);

  // State register together with all registered outputs and the dwell
  // counter. One process holds the FSM so state and outputs always change
  // on the same edge.
  // NOTE: every register here is assigned with <=. With <=, each branch reads
  // the pre-edge values of state_q, idx_q and d_q, whatever the statement
  // order. Blocking assignments would let later lines see half-updated state.
  // The reset branch is asynchronous, so outputs clear as soon as rst_n falls
  // and do not wait for the next clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (!en) begin
      // Dropping en returns to IDLE from any state and clears everything.
      state_q <= IDLE;
      d_q     <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // Both pulses default low, so each lasts exactly one cycle.
      wrap_q <= 1'b0;
      err_q  <= 1'b0;

      case (state_q)
        // IDLE and DIRECT share the same next-state rule. A load that
        // arrives on the IDLE -> DIRECT edge takes effect on that edge.
        IDLE, DIRECT: begin
          if (mode) begin
            // Scan always starts from position 0, whatever direct mode left.
            state_q <= SCAN;
            idx_q   <= '0;
            d_q     <= OH_FIRST;
            cnt_q   <= '0;
          end else begin
            state_q <= DIRECT;
            if (ld) begin
              idx_q <= sel;
              d_q   <= sel_onehot;
              err_q <= ~sel_in_range;
            end
          end
        end

        SCAN: begin
          if (!mode) begin
            // Leaving scan freezes d and idx until the next direct load.
            state_q <= DIRECT;
          end else if (dwell_done) begin
            cnt_q <= '0;
            if (scan_at_last) begin
              idx_q  <= '0;
              d_q    <= OH_FIRST;
              wrap_q <= 1'b1;
            end else begin
              idx_q <= idx_q + SEL_W'(1);
              d_q   <= d_q << 1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          // The unused encoding recovers to a clean IDLE.
          state_q <= IDLE;
          d_q     <= '0;
          idx_q   <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign d    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign err  = err_q;

`ifndef SYNTHESIS
  // d must be all zero or have exactly one bit set.
  a_d_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(d_q));

  // A wrap pulse must always coincide with d back at bit 0.
  a_wrap_at_first: assert property (@(posedge clk) disable iff (!rst_n)
    wrap_q |-> (d_q == OH_FIRST));

  // Only one of wrap and err can be active in a cycle.
  a_pulse_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(wrap_q && err_q));
`endif

endmodule
